stream_packer: RTL and testbench
================================

STREAM_PACKER -- requirements
Module: stream_packer

Interface
REQ-001 Parameter IN_WIDTH, default 8, SHALL set the input lane width in bits.
REQ-002 Parameter RATIO, default 4, SHALL set the number of lanes per output word (legal range 2..16).
REQ-003 Parameter TIMEOUT, default 16, SHALL set the idle cycles before a partial word auto-flushes (legal range 1..255).
REQ-004 i_clk  in  1  SHALL be the single clock, rising edge.
REQ-005 i_rst_n  in  1  SHALL be the asynchronous, active-low reset.
REQ-006 i_in_valid  in  1  SHALL indicate an input lane is offered (driven by FIFO o_pop_valid).
REQ-007 i_in_data  in  IN_WIDTH  SHALL carry the offered lane (FIFO o_pop_data).
REQ-008 o_in_ready  out  1  SHALL accept the lane when high with i_in_valid (drives FIFO i_pop_ready).
REQ-009 i_flush  in  1  SHALL request a single-cycle flush of any partial word.
REQ-010 o_out_valid  out  1  SHALL indicate o_out_data/o_out_keep are valid.
REQ-011 o_out_data  out  IN_WIDTH*RATIO  SHALL carry the packed word.
REQ-012 o_out_keep  out  RATIO  SHALL flag the valid lanes, one bit per lane.
REQ-013 i_out_ready  in  1  SHALL accept the output word when high with o_out_valid.

Function
REQ-014 Transfers SHALL occur only on edges where valid and ready are both high, on both ports.
REQ-015 Lane k of a word (k = 0 for the first accepted) SHALL occupy bits [k*IN_WIDTH +: IN_WIDTH] and set keep[k].
REQ-016 The block SHALL hold an accumulation register plus a lane index, and a separate output register.
REQ-017 Accumulator FSM states SHALL be S_EMPTY, S_PARTIAL and S_FLUSH_PEND.
REQ-018 A lane accepted in S_EMPTY SHALL move the FSM to S_PARTIAL, or straight to word completion when RATIO==1 (illegal).
REQ-019 Completion SHALL occur on acceptance of lane RATIO-1: the full word (keep all ones) loads the output register and the FSM returns to S_EMPTY.
REQ-020 A flush request (i_flush, or idle count reaching TIMEOUT) in S_PARTIAL SHALL load the partial word with its keep mask into the output register.
REQ-021 A flush request in S_EMPTY SHALL be ignored, with no output.
REQ-022 A lane accepted on the same edge as i_flush SHALL be included in the flushed word.
REQ-023 If a load is required while the output register is occupied and not draining this cycle, the FSM SHALL go to S_FLUSH_PEND (flush) or deassert o_in_ready (completion) until the register frees.
REQ-024 o_in_ready SHALL be low in S_FLUSH_PEND.
REQ-025 o_in_ready SHALL be low when the lane index is RATIO-1, o_out_valid=1 and i_out_ready=0; otherwise it SHALL be high.
REQ-026 The output register SHALL be loaded on the same edge it drains, sustaining one word per RATIO input cycles.
REQ-027 The idle counter SHALL clear on any accepted lane or on leaving S_PARTIAL, increment each cycle in S_PARTIAL without acceptance, and saturate at TIMEOUT.
REQ-028 o_out_data and o_out_keep SHALL be held stable while o_out_valid=1 and i_out_ready=0.
REQ-029 Latency from acceptance of the completing lane to o_out_valid SHALL be 1 cycle.
REQ-030 Unused lanes of a partial word SHALL read as zero.

Reset
REQ-031 Asserting i_rst_n low SHALL immediately force: FSM S_EMPTY, lane index 0, idle count 0, o_out_valid 0, o_out_data 0, o_out_keep 0.
REQ-032 Data in flight when reset asserts mid-operation SHALL be discarded silently; o_in_ready SHALL be 1 after reset.

Structure
REQ-033 Package stream_packer_pkg SHALL hold the FSM state enum and a KEEP_ALL function returning RATIO ones.
REQ-034 The idle counter SHALL be a sub-module, idle_timer (clear, enable, TIMEOUT parameter, expired output).
REQ-035 The block SHALL contain no RAM; all storage SHALL be flops.

Verification
REQ-036 Stream 0x11,0x22,0x33,0x44 with i_out_ready=1 -> one word 0x44332211, keep 4'b1111, one cycle after the 4th lane.
REQ-037 Send 0xAA,0xBB, then i_flush -> word 0x0000BBAA, keep 4'b0011; the next lane starts at lane 0.
REQ-038 Send 0x5A, then 16 idle cycles -> auto-flush word 0x0000005A, keep 4'b0001; no output at 15 idle cycles.
REQ-039 Send 8 lanes back-to-back with i_out_ready=0 -> o_in_ready drops on the 8th lane; raise i_out_ready -> 0x..first then second word, no loss.
REQ-040 Assert i_flush in S_EMPTY -> no o_out_valid; flush with a simultaneous lane 0x77 in S_PARTIAL(0x66) -> keep 4'b0011, data 0x00007766.
REQ-041 Assert reset after 2 lanes -> outputs 0 and no word emitted; the next 4 lanes form a clean word.

Source files
------------

// File: rtl/stream_packer_pkg.sv
// Shared types and helpers for the stream packer.
package stream_packer_pkg;

   localparam int MAX_RATIO = 16;

   typedef enum logic [1:0] {
      S_EMPTY,
      S_PARTIAL,
      S_FLUSH_PEND
   } state_e;

   function automatic logic [MAX_RATIO-1:0] KEEP_ALL(input int ratio);
      logic [MAX_RATIO-1:0] k;
      k = '0;
      for (int i = 0; i < MAX_RATIO; i++) begin
         k[i] = (i < ratio);
      end
      return k;
   endfunction

endpackage

// File: rtl/idle_timer.sv
// Saturating idle counter; expired fires on the edge the count reaches TIMEOUT.
module idle_timer #(
   parameter int TIMEOUT = 16
) (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic clear_i,
   input  logic enable_i,
   output logic expired_o
);

   localparam logic [7:0] CNT_MAX  = 8'(TIMEOUT);
   localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

   logic [7:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clear_i) begin
         cnt_d = '0;
      end else if (enable_i && cnt_q != CNT_MAX) begin
         cnt_d = cnt_q + 8'd1;
      end
   end

   assign expired_o = enable_i && !clear_i && (cnt_q >= CNT_LAST);

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/stream_packer.sv
// Packs IN_WIDTH lanes into RATIO-lane words with a keep mask; partial
// words leave on i_flush or after TIMEOUT idle cycles.
module stream_packer
   import stream_packer_pkg::*;
#(
   parameter int IN_WIDTH = 8,
   parameter int RATIO    = 4,
   parameter int TIMEOUT  = 16
) (
   input  logic                      i_clk,
   input  logic                      i_rst_n,
   input  logic                      i_in_valid,
   input  logic [IN_WIDTH-1:0]       i_in_data,
   output logic                      o_in_ready,
   input  logic                      i_flush,
   output logic                      o_out_valid,
   output logic [IN_WIDTH*RATIO-1:0] o_out_data,
   output logic [RATIO-1:0]          o_out_keep,
   input  logic                      i_out_ready
);

   localparam int OW = IN_WIDTH * RATIO;
   localparam int LW = $clog2(RATIO + 1);
   localparam logic [LW-1:0] LAST_LANE = LW'(RATIO - 1);
   localparam logic [MAX_RATIO-1:0] KEEP_FULL = KEEP_ALL(RATIO);

   state_e          state_q;
   logic [LW-1:0]   lane_q;
   logic [OW-1:0]   acc_q;
   logic            out_valid_q;
   logic [OW-1:0]   out_data_q;
   logic [RATIO-1:0] out_keep_q;

   logic            accept;
   logic            out_free;
   logic            complete;
   logic            flush_req;
   logic            expired;
   logic            tmr_en;
   logic            tmr_clear;
   logic            load;
   logic [LW-1:0]   lanes_n;
   logic [OW-1:0]   ins;
   logic [OW-1:0]   word_n;
   logic [RATIO-1:0] keep_part;
   logic [RATIO-1:0] ld_keep;

   assign out_free   = !out_valid_q || i_out_ready;
   assign o_in_ready = (state_q != S_FLUSH_PEND) &&
                       !(lane_q == LAST_LANE && out_valid_q && !i_out_ready);
   assign accept     = i_in_valid && o_in_ready;
   assign complete   = accept && (lane_q == LAST_LANE);
   assign lanes_n    = lane_q + LW'(accept);
   assign ins        = OW'(i_in_data) << (int'(lane_q) * IN_WIDTH);
   assign word_n     = accept ? (acc_q | ins) : acc_q;

   assign tmr_en    = (state_q == S_PARTIAL) && !accept;
   assign tmr_clear = accept || (state_q != S_PARTIAL);
   assign flush_req = i_flush || expired;

   idle_timer #(
      .TIMEOUT(TIMEOUT)
   ) u_idle (
      .clk_i    (i_clk),
      .rst_ni   (i_rst_n),
      .clear_i  (tmr_clear),
      .enable_i (tmr_en),
      .expired_o(expired)
   );

   always_comb begin
      keep_part = '0;
      for (int i = 0; i < RATIO; i++) begin
         keep_part[i] = (i < int'(lanes_n));
      end
   end

   assign ld_keep = complete ? KEEP_FULL[RATIO-1:0] : keep_part;

   // A pending flush and a same-edge lane both resolve through word_n.
   assign load = complete ||
                 (state_q == S_PARTIAL && flush_req && out_free) ||
                 (state_q == S_FLUSH_PEND && out_free);

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q     <= S_EMPTY;
         lane_q      <= '0;
         acc_q       <= '0;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_keep_q  <= '0;
      end else if (load) begin
         out_valid_q <= 1'b1;
         out_data_q  <= word_n;
         out_keep_q  <= ld_keep;
         acc_q       <= '0;
         lane_q      <= '0;
         state_q     <= S_EMPTY;
      end else begin
         if (i_out_ready) begin
            out_valid_q <= 1'b0;
         end
         if (state_q == S_PARTIAL && flush_req) begin
            acc_q   <= word_n;
            lane_q  <= lanes_n;
            state_q <= S_FLUSH_PEND;
         end else if (accept) begin
            acc_q   <= word_n;
            lane_q  <= lanes_n;
            state_q <= S_PARTIAL;
         end
      end
   end

   assign o_out_valid = out_valid_q;
   assign o_out_data  = out_data_q;
   assign o_out_keep  = out_keep_q;

endmodule

// File: tb/tb_stream_packer.sv
// Directed bench for stream_packer with a lane-list reference model.
module tb_stream_packer;

   localparam int W = 8;
   localparam int R = 4;
   localparam int T = 16;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          i_in_valid;
   logic [W-1:0]  i_in_data;
   logic          o_in_ready;
   logic          i_flush;
   logic          o_out_valid;
   logic [W*R-1:0] o_out_data;
   logic [R-1:0]  o_out_keep;
   logic          i_out_ready;

   int n_tests = 0;
   int n_fail  = 0;

   stream_packer #(
      .IN_WIDTH(W),
      .RATIO   (R),
      .TIMEOUT (T)
   ) dut (
      .i_clk      (clk),
      .i_rst_n    (rst_n),
      .i_in_valid (i_in_valid),
      .i_in_data  (i_in_data),
      .o_in_ready (o_in_ready),
      .i_flush    (i_flush),
      .o_out_valid(o_out_valid),
      .o_out_data (o_out_data),
      .o_out_keep (o_out_keep),
      .i_out_ready(i_out_ready)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act,
                        input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Reference model: lanes gathered so far, idle run length, output slot.
   int          m_n;
   logic [31:0] m_acc;
   bit          m_pend;
   int          m_idle;
   bit          m_ov;
   logic [31:0] m_od;
   logic [3:0]  m_ok;

   function automatic bit m_ready();
      return !m_pend && !(m_n == R - 1 && m_ov && !i_out_ready);
   endfunction

   task automatic m_emit();
      m_ov   = 1'b1;
      m_od   = m_acc;
      m_ok   = 4'((1 << m_n) - 1);
      m_acc  = '0;
      m_n    = 0;
      m_idle = 0;
      m_pend = 1'b0;
   endtask

   always @(posedge clk) begin
      bit acc, free, partial, freq;
      if (!rst_n) begin
         m_n = 0; m_acc = '0; m_pend = 1'b0; m_idle = 0;
         m_ov = 1'b0; m_od = '0; m_ok = '0;
      end else begin
         acc     = i_in_valid && m_ready();
         free    = !m_ov || i_out_ready;
         partial = (m_n > 0) && !m_pend;
         if (free) m_ov = 1'b0;
         if (acc) begin
            m_acc[m_n*W +: W] = i_in_data;
            m_n++;
         end
         if (partial && !acc) m_idle++;
         else m_idle = 0;
         freq = i_flush || (m_idle >= T);
         if (m_pend) begin
            if (free) m_emit();
         end else if (m_n == R) begin
            m_emit();
         end else if (partial && freq) begin
            if (free) m_emit();
            else begin
               m_pend = 1'b1;
               m_idle = 0;
            end
         end
      end
   end

   always @(negedge clk) begin
      if (rst_n) begin
         check("in_ready", 32'(o_in_ready), 32'(m_ready()));
         check("out_valid", 32'(o_out_valid), 32'(m_ov));
         if (m_ov) begin
            check("out_data", o_out_data, m_od);
            check("out_keep", 32'(o_out_keep), 32'(m_ok));
         end
      end
   end

   logic [31:0] cap_d[$];
   logic [3:0]  cap_k[$];

   always @(posedge clk) begin
      if (rst_n && o_out_valid && i_out_ready) begin
         cap_d.push_back(o_out_data);
         cap_k.push_back(o_out_keep);
      end
   end

   task automatic expect_word(input string name, input logic [31:0] d,
                              input logic [3:0] k);
      if (cap_d.size() == 0) begin
         n_tests++;
         n_fail++;
         $display("FAIL %s: got no word expected %h/%h", name, d, k);
      end else begin
         check({name, " data"}, cap_d.pop_front(), d);
         check({name, " keep"}, 32'(cap_k.pop_front()), 32'(k));
      end
   endtask

   task automatic expect_none(input string name);
      check(name, 32'(cap_d.size()), 32'd0);
   endtask

   task automatic cycles(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic send(input logic [7:0] d, input bit f);
      bit r;
      bit done;
      done       = 1'b0;
      i_in_valid = 1'b1;
      i_in_data  = d;
      i_flush    = f;
      for (int i = 0; i < 50 && !done; i++) begin
         @(negedge clk);
         r = o_in_ready;
         @(posedge clk);
         #1;
         done = r;
      end
      if (!done) begin
         n_tests++;
         n_fail++;
         $display("FAIL send %h: not accepted within 50 cycles", d);
      end
      i_in_valid = 1'b0;
      i_flush    = 1'b0;
   endtask

   task automatic flush_pulse();
      i_flush = 1'b1;
      @(posedge clk);
      #1;
      i_flush = 1'b0;
   endtask

   initial begin
      rst_n       = 1'b0;
      i_in_valid  = 1'b0;
      i_in_data   = '0;
      i_flush     = 1'b0;
      i_out_ready = 1'b1;
      cycles(2);
      check("reset valid", 32'(o_out_valid), 32'd0);
      check("reset data", o_out_data, 32'd0);
      check("reset keep", 32'(o_out_keep), 32'd0);
      rst_n = 1'b1;
      cycles(1);
      check("reset ready", 32'(o_in_ready), 32'd1);

      // Full word, one-cycle latency
      send(8'h11, 0); send(8'h22, 0); send(8'h33, 0);
      check("no early word", 32'(o_out_valid), 32'd0);
      send(8'h44, 0);
      check("latency valid", 32'(o_out_valid), 32'd1);
      check("latency data", o_out_data, 32'h44332211);
      cycles(1);
      expect_word("full", 32'h44332211, 4'b1111);

      // Explicit flush, then restart at lane 0
      send(8'hAA, 0); send(8'hBB, 0);
      flush_pulse();
      cycles(1);
      expect_word("flush", 32'h0000BBAA, 4'b0011);
      send(8'h01, 0); send(8'h02, 0); send(8'h03, 0); send(8'h04, 0);
      cycles(1);
      expect_word("after flush", 32'h04030201, 4'b1111);

      // Idle timeout
      send(8'h5A, 0);
      cycles(T - 1);
      check("no timeout at 15", 32'(o_out_valid), 32'd0);
      expect_none("no timeout word");
      cycles(1);
      check("timeout valid", 32'(o_out_valid), 32'd1);
      check("timeout data", o_out_data, 32'h0000005A);
      cycles(1);
      expect_word("timeout", 32'h0000005A, 4'b0001);

      // Backpressure: 8th lane stalls, both words delivered
      i_out_ready = 1'b0;
      for (int i = 0; i < 7; i++) send(8'(8'h10 + i), 0);
      i_in_valid = 1'b1;
      i_in_data  = 8'h17;
      repeat (3) begin
         @(negedge clk);
         check("stall ready", 32'(o_in_ready), 32'd0);
         check("stall hold", o_out_data, 32'h13121110);
      end
      @(posedge clk);
      #1;
      i_out_ready = 1'b1;
      @(negedge clk);
      check("resume ready", 32'(o_in_ready), 32'd1);
      @(posedge clk);
      #1;
      i_in_valid = 1'b0;
      cycles(2);
      expect_word("bp first", 32'h13121110, 4'b1111);
      expect_word("bp second", 32'h17161514, 4'b1111);

      // Flush in empty state, then flush with a same-edge lane
      flush_pulse();
      cycles(2);
      expect_none("empty flush");
      send(8'h66, 0);
      send(8'h77, 1);
      cycles(1);
      expect_word("flush+lane", 32'h00007766, 4'b0011);

      // Flush while output register is busy
      i_out_ready = 1'b0;
      for (int i = 0; i < 6; i++) send(8'(8'h20 + i), 0);
      flush_pulse();
      @(negedge clk);
      check("pend ready", 32'(o_in_ready), 32'd0);
      cycles(2);
      i_out_ready = 1'b1;
      cycles(3);
      expect_word("pend first", 32'h23222120, 4'b1111);
      expect_word("pend second", 32'h00002524, 4'b0011);

      // Reset mid-operation discards everything
      i_out_ready = 1'b0;
      for (int i = 0; i < 6; i++) send(8'(8'h30 + i), 0);
      rst_n = 1'b0;
      #1;
      check("mid reset valid", 32'(o_out_valid), 32'd0);
      check("mid reset data", o_out_data, 32'd0);
      check("mid reset keep", 32'(o_out_keep), 32'd0);
      check("mid reset ready", 32'(o_in_ready), 32'd1);
      cycles(2);
      rst_n       = 1'b1;
      i_out_ready = 1'b1;
      cycles(1);
      expect_none("reset no word");
      send(8'h40, 0); send(8'h41, 0); send(8'h42, 0); send(8'h43, 0);
      cycles(1);
      expect_word("post reset", 32'h43424140, 4'b1111);
      cycles(2);
      expect_none("no extra words");

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

endmodule
